ram_access_ctrl: RTL and testbench

//   Initiator for the single-port synchronous RAM port (EN/WR/A/D/Q, 1-cycle registered read).

---
 rtl/ram_access_ctrl_pkg.sv | 19 +
 rtl/ram_ctrl_rsp_fifo.sv | 52 +++++
 rtl/ram_access_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// Shared FSM encoding and default geometry for ram_access_ctrl.
// ST_VERIFY exists only when RAM_CTRL_WRITE_VERIFY_EN is defined.
package ram_access_ctrl_pkg;

    localparam int DEF_AW        = 4;
    localparam int DEF_DW        = 4;
    localparam int DEF_LW        = 3;
    localparam int DEF_RSP_DEPTH = 4;
    localparam int DEF_WMASK     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        , ST_VERIFY = 2'd2
`endif
    } state_e;

endpackage

// File: rtl/ram_ctrl_rsp_fifo.sv
// Synchronous response FIFO; push and pop may coincide at any fill level.
// Reset is asynchronous, active-high, and empties the FIFO.
module ram_ctrl_rsp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_data_o,
    output logic [PW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // NOTE: storage is not reset; empty masks stale entries, so only pointers and count need reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ram_access_ctrl.sv
// Burst initiator for a single-port synchronous RAM with credited read responses.
// Optional write-verify read-back is enabled by defining RAM_CTRL_WRITE_VERIFY_EN.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int             AW        = DEF_AW,
    parameter int             DW        = DEF_DW,
    parameter int             LW        = DEF_LW,
    parameter int             RSP_DEPTH = DEF_RSP_DEPTH,
    parameter logic [DW-1:0]  WMASK     = DW'(DEF_WMASK)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic          CMD_WR,
    input  logic [AW-1:0] CMD_ADDR,
    input  logic [LW-1:0] CMD_LEN,
    input  logic [DW-1:0] CMD_WDATA,
    output logic          RAM_EN,
    output logic          RAM_WR,
    output logic [AW-1:0] RAM_A,
    output logic [DW-1:0] RAM_D,
    input  logic [DW-1:0] RAM_Q,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic [DW-1:0] RSP_DATA,
    output logic          BUSY,
    output logic          VERIFY_ERR
);

    localparam int             CW      = $clog2(RSP_DEPTH);
    localparam logic [CW:0]    DEPTH_V = (CW+1)'(RSP_DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          inflight_q, inflight_d;
    logic          live_q;
    logic [CW:0]   fifo_count;
    logic          fifo_empty;
    logic          fifo_full_unused;
    logic          can_read;
    logic          advance;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    logic          vpend_q, vpend_d;
    logic          verr_q;
`endif

    // Same-cycle pops are deliberately not credited back.
    assign can_read = (fifo_count + (CW+1)'(inflight_q)) < DEPTH_V;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            inflight_q <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            inflight_q <= inflight_d;
            live_q     <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every value written here is defaulted first so no path can infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        inflight_d = 1'b0;
        advance    = 1'b0;
        CMD_READY  = 1'b0;
        RAM_EN     = 1'b0;
        RAM_WR     = 1'b0;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        vpend_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                CMD_READY = live_q;
                if (CMD_VALID && live_q) begin
                    wr_d    = CMD_WR;
                    addr_d  = CMD_ADDR;
                    rem_d   = CMD_LEN;
                    wdata_d = CMD_WDATA;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wr_q || can_read) begin
                    RAM_EN     = 1'b1;
                    RAM_WR     = wr_q;
                    inflight_d = !wr_q;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
                    if (wr_q) state_d = ST_VERIFY;
                    else      advance = 1'b1;
`else
                    advance = 1'b1;
`endif
                end
            end
`ifdef RAM_CTRL_WRITE_VERIFY_EN
            ST_VERIFY: begin
                RAM_EN  = 1'b1;
                vpend_d = 1'b1;
                advance = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (advance) begin
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = (rem_q == '0) ? ST_IDLE : ST_BURST;
        end
    end

    assign RAM_A     = addr_q;
    assign RAM_D     = wdata_q;
    assign RSP_VALID = !fifo_empty;

    ram_ctrl_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .DW    (DW)
    ) u_rsp_fifo (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (inflight_q),
        .push_data_i (RAM_Q),
        .pop_i       (RSP_READY),
        .pop_data_o  (RSP_DATA),
        .count_o     (fifo_count),
        .full_o      (fifo_full_unused),
        .empty_o     (fifo_empty)
    );

`ifdef RAM_CTRL_WRITE_VERIFY_EN
    // Verify reads are compared one cycle later, against what the RAM actually stores.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vpend_q <= 1'b0;
            verr_q  <= 1'b0;
        end else begin
            vpend_q <= vpend_d;
            verr_q  <= verr_q | (vpend_q && (RAM_Q != (wdata_q & WMASK)));
        end
    end
    assign VERIFY_ERR = verr_q;
    assign BUSY = (state_q != ST_IDLE) || inflight_q || vpend_q || !fifo_empty;
`else
    logic unused_wmask;
    assign unused_wmask = ^WMASK;
    assign VERIFY_ERR   = 1'b0;
    assign BUSY = (state_q != ST_IDLE) || inflight_q || !fifo_empty;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed self-checking bench for ram_access_ctrl with a behavioural RAM model.
// Adapts expected write timing when RAM_CTRL_WRITE_VERIFY_EN is defined.
module tb_ram_access_ctrl;

    localparam int            AW = 4;
    localparam int            DW = 4;
    localparam int            LW = 3;
    localparam int            RSP_DEPTH = 4;
    localparam logic [DW-1:0] WMASK = 4'h3;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    localparam int            WCYC = 2;
`else
    localparam int            WCYC = 1;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic          CMD_WR = 1'b0;
    logic [AW-1:0] CMD_ADDR = '0;
    logic [LW-1:0] CMD_LEN = '0;
    logic [DW-1:0] CMD_WDATA = '0;
    logic          RAM_EN;
    logic          RAM_WR;
    logic [AW-1:0] RAM_A;
    logic [DW-1:0] RAM_D;
    logic [DW-1:0] RAM_Q;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b0;
    logic [DW-1:0] RSP_DATA;
    logic          BUSY;
    logic          VERIFY_ERR;

    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ram_q_raw = '0;
    logic          corrupt = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    ram_access_ctrl #(
        .AW(AW), .DW(DW), .LW(LW), .RSP_DEPTH(RSP_DEPTH), .WMASK(WMASK)
    ) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
        .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .CMD_WDATA(CMD_WDATA),
        .RAM_EN(RAM_EN), .RAM_WR(RAM_WR), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_Q(RAM_Q),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .BUSY(BUSY), .VERIFY_ERR(VERIFY_ERR)
    );

    always #5 CLK = ~CLK;

    // RAM macro model: masked write, one-cycle registered read.
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WR) ram_mem[RAM_A] <= RAM_D & WMASK;
            else        ram_q_raw <= ram_mem[RAM_A];
        end
    end
    assign RAM_Q = ram_q_raw ^ (corrupt ? 4'hF : 4'h0);

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a,
                            input logic [LW-1:0] len, input logic [DW-1:0] wd);
        int waited;
        waited    = 0;
        CMD_VALID = 1'b1;
        CMD_WR    = wr;
        CMD_ADDR  = a;
        CMD_LEN   = len;
        CMD_WDATA = wd;
        @(negedge CLK);
        while (!CMD_READY && waited < 20) begin
            next_cycle();
            @(negedge CLK);
            waited++;
        end
        n_checks++;
        if (CMD_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_accept: CMD_READY=%b after %0d cycles, required 1", CMD_READY, waited);
        end
        next_cycle();
        CMD_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if ({CMD_READY, RAM_EN, RAM_WR, RSP_VALID, BUSY, VERIFY_ERR, RAM_A, RAM_D, RSP_DATA} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b en=%b wr=%b vld=%b busy=%b verr=%b a=%h d=%h rsp=%h, required all 0",
                     CMD_READY, RAM_EN, RAM_WR, RSP_VALID, BUSY, VERIFY_ERR, RAM_A, RAM_D, RSP_DATA);
        end
        next_cycle();
        RST = 1'b0;
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: CMD_READY=%b BUSY=%b, required 1 0", CMD_READY, BUSY);
        end
        next_cycle();
    endtask

    task automatic test_write_read();
        RSP_READY = 1'b1;
        send_cmd(1'b1, 4'h2, 3'd0, 4'h3);
        @(negedge CLK);
        n_checks++;
        if ({RAM_EN, RAM_WR, RAM_A, RAM_D} !== {1'b1, 1'b1, 4'h2, 4'h3}) begin
            n_fail++;
            $display("FAIL wr_beat: en=%b wr=%b a=%h d=%h, required 1 1 2 3", RAM_EN, RAM_WR, RAM_A, RAM_D);
        end
        next_cycle();
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        next_cycle();
`endif
        send_cmd(1'b0, 4'h2, 3'd0, 4'h0);
        @(negedge CLK);
        n_checks++;
        if ({RAM_EN, RAM_WR, RAM_A} !== {1'b1, 1'b0, 4'h2}) begin
            n_fail++;
            $display("FAIL rd_beat: en=%b wr=%b a=%h, required 1 0 2", RAM_EN, RAM_WR, RAM_A);
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (RSP_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_cycle2_valid: got %b, required 0", RSP_VALID);
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (RSP_VALID !== 1'b1 || RSP_DATA !== 4'h3) begin
            n_fail++;
            $display("FAIL rd_cycle3_data: valid=%b data=%h, required 1 3", RSP_VALID, RSP_DATA);
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_drained: valid=%b busy=%b, required 0 0", RSP_VALID, BUSY);
        end
        next_cycle();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a;
        send_cmd(1'b1, 4'hE, 3'd3, 4'h5);
        for (int k = 0; k < 4; k++) begin
            exp_a = 4'hE + 4'(k);
            @(negedge CLK);
            n_checks++;
            if ({RAM_EN, RAM_WR, RAM_A, CMD_READY} !== {1'b1, 1'b1, exp_a, 1'b0}) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: en=%b wr=%b a=%h rdy=%b, required 1 1 %h 0",
                         k, RAM_EN, RAM_WR, RAM_A, CMD_READY, exp_a);
            end
            next_cycle();
`ifdef RAM_CTRL_WRITE_VERIFY_EN
            @(negedge CLK);
            n_checks++;
            if ({RAM_EN, RAM_WR, RAM_A, CMD_READY} !== {1'b1, 1'b0, exp_a, 1'b0}) begin
                n_fail++;
                $display("FAIL wrap_verify%0d: en=%b wr=%b a=%h rdy=%b, required 1 0 %h 0",
                         k, RAM_EN, RAM_WR, RAM_A, CMD_READY, exp_a);
            end
            next_cycle();
`endif
        end
        @(negedge CLK);
        n_checks++;
        if (CMD_READY !== 1'b1 || RAM_EN !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_end: rdy=%b en=%b, required 1 0", CMD_READY, RAM_EN);
        end
        next_cycle();
    endtask

    task automatic test_credit();
        int beats;
        int rsp;
        int guard;
        logic [DW-1:0] exp_d;
        beats = 0;
        rsp   = 0;
        guard = 0;
        RSP_READY = 1'b0;
        send_cmd(1'b0, 4'h4, 3'd7, 4'h0);
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (RAM_EN) beats++;
            next_cycle();
        end
        n_checks++;
        if (beats != 4) begin
            n_fail++;
            $display("FAIL credit_stall_beats: got %0d beats, required 4", beats);
        end
        @(negedge CLK);
        n_checks++;
        if ({RAM_EN, RSP_VALID, BUSY, RAM_A} !== {1'b0, 1'b1, 1'b1, 4'h8}) begin
            n_fail++;
            $display("FAIL credit_stalled: en=%b vld=%b busy=%b a=%h, required 0 1 1 8",
                     RAM_EN, RSP_VALID, BUSY, RAM_A);
        end
        next_cycle();
        RSP_READY = 1'b1;
        while (rsp < 8 && guard < 80) begin
            @(negedge CLK);
            if (RAM_EN) beats++;
            if (RSP_VALID) begin
                exp_d = 4'(15 - (4 + rsp));
                n_checks++;
                if (RSP_DATA !== exp_d) begin
                    n_fail++;
                    $display("FAIL credit_rsp%0d: got %h, required %h", rsp, RSP_DATA, exp_d);
                end
                rsp++;
            end
            next_cycle();
            guard++;
        end
        @(negedge CLK);
        n_checks++;
        if (rsp != 8 || beats != 8 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_totals: rsp=%0d beats=%0d busy=%b, required 8 8 0", rsp, beats, BUSY);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        logic bad;
        bad = 1'b0;
        RSP_READY = 1'b0;
        send_cmd(1'b0, 4'h4, 3'd5, 4'h0);
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (RAM_EN !== 1'b1 || RAM_A !== 4'h5) begin
            n_fail++;
            $display("FAIL rstmid_beat2: en=%b a=%h, required 1 5", RAM_EN, RAM_A);
        end
        RST = 1'b1;
        #1;
        n_checks++;
        if ({CMD_READY, RAM_EN, RAM_WR, RSP_VALID, BUSY, VERIFY_ERR, RAM_A, RAM_D, RSP_DATA} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: rdy=%b en=%b wr=%b vld=%b busy=%b a=%h rsp=%h, required all 0",
                     CMD_READY, RAM_EN, RAM_WR, RSP_VALID, BUSY, RAM_A, RSP_DATA);
        end
        next_cycle();
        RST = 1'b0;
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (CMD_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_ready: got %b, required 1", CMD_READY);
        end
        for (int c = 0; c < 4; c++) begin
            if (RSP_VALID !== 1'b0 || RAM_EN !== 1'b0 || BUSY !== 1'b0) bad = 1'b1;
            next_cycle();
            @(negedge CLK);
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: activity seen after reset, required none");
        end
        next_cycle();
    endtask

    task automatic test_verify();
        RSP_READY = 1'b1;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        send_cmd(1'b1, 4'h1, 3'd0, 4'h7);
        @(negedge CLK);
        n_checks++;
        if ({RAM_EN, RAM_WR, RAM_A, RAM_D} !== {1'b1, 1'b1, 4'h1, 4'h7}) begin
            n_fail++;
            $display("FAIL vfy_write: en=%b wr=%b a=%h d=%h, required 1 1 1 7", RAM_EN, RAM_WR, RAM_A, RAM_D);
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if ({RAM_EN, RAM_WR, RAM_A, CMD_READY} !== {1'b1, 1'b0, 4'h1, 1'b0}) begin
            n_fail++;
            $display("FAIL vfy_read: en=%b wr=%b a=%h rdy=%b, required 1 0 1 0", RAM_EN, RAM_WR, RAM_A, CMD_READY);
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (CMD_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL vfy_two_cycles: rdy=%b, required 1", CMD_READY);
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (VERIFY_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL vfy_clean: VERIFY_ERR=%b, required 0", VERIFY_ERR);
        end
        next_cycle();
        corrupt = 1'b1;
        send_cmd(1'b1, 4'h1, 3'd0, 4'h7);
        next_cycle();
        next_cycle();
        next_cycle();
        corrupt = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (VERIFY_ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL vfy_corrupt: VERIFY_ERR=%b, required 1", VERIFY_ERR);
        end
        next_cycle();
        send_cmd(1'b1, 4'h1, 3'd0, 4'h7);
        for (int c = 0; c < 4; c++) next_cycle();
        @(negedge CLK);
        n_checks++;
        if (VERIFY_ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL vfy_sticky: VERIFY_ERR=%b, required 1", VERIFY_ERR);
        end
        next_cycle();
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (VERIFY_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL vfy_rst_clear: VERIFY_ERR=%b, required 0", VERIFY_ERR);
        end
        next_cycle();
        RST = 1'b0;
        next_cycle();
`else
        corrupt = 1'b1;
        send_cmd(1'b1, 4'h1, 3'd0, 4'h7);
        @(negedge CLK);
        n_checks++;
        if ({RAM_EN, RAM_WR, RAM_A, RAM_D} !== {1'b1, 1'b1, 4'h1, 4'h7}) begin
            n_fail++;
            $display("FAIL vfy_write: en=%b wr=%b a=%h d=%h, required 1 1 1 7", RAM_EN, RAM_WR, RAM_A, RAM_D);
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (CMD_READY !== 1'b1 || RAM_EN !== 1'b0) begin
            n_fail++;
            $display("FAIL vfy_one_cycle: rdy=%b en=%b, required 1 0", CMD_READY, RAM_EN);
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (VERIFY_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL vfy_tied: VERIFY_ERR=%b, required 0", VERIFY_ERR);
        end
        corrupt = 1'b0;
        next_cycle();
`endif
    endtask

    task automatic test_back_to_back();
        int waited;
        logic bad;
        waited = 0;
        bad    = 1'b0;
        RSP_READY = 1'b0;
        send_cmd(1'b1, 4'h8, 3'd0, 4'h2);
        CMD_VALID = 1'b1;
        CMD_WR    = 1'b0;
        CMD_ADDR  = 4'h8;
        CMD_LEN   = 3'd1;
        @(negedge CLK);
        n_checks++;
        if (RAM_WR !== 1'b1 || CMD_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_last_wr: wr=%b rdy=%b, required 1 0", RAM_WR, CMD_READY);
        end
        next_cycle();
        @(negedge CLK);
        while (!CMD_READY && waited < 10) begin
            next_cycle();
            @(negedge CLK);
            waited++;
        end
        n_checks++;
        if (CMD_READY !== 1'b1 || waited != WCYC - 1) begin
            n_fail++;
            $display("FAIL b2b_accept: rdy=%b waited=%0d, required 1 %0d", CMD_READY, waited, WCYC - 1);
        end
        next_cycle();
        CMD_VALID = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({RAM_EN, RAM_WR, RAM_A} !== {1'b1, 1'b0, 4'h8}) begin
            n_fail++;
            $display("FAIL b2b_rd0: en=%b wr=%b a=%h, required 1 0 8", RAM_EN, RAM_WR, RAM_A);
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if ({RAM_EN, RAM_WR, RAM_A} !== {1'b1, 1'b0, 4'h9}) begin
            n_fail++;
            $display("FAIL b2b_rd1: en=%b wr=%b a=%h, required 1 0 9", RAM_EN, RAM_WR, RAM_A);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge CLK);
            if (BUSY !== 1'b1 || RSP_VALID !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy_hold: BUSY or RSP_VALID dropped while FIFO full of data, required 1");
        end
        next_cycle();
        RSP_READY = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({RSP_VALID, RSP_DATA, BUSY} !== {1'b1, 4'h2, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_rsp0: vld=%b data=%h busy=%b, required 1 2 1", RSP_VALID, RSP_DATA, BUSY);
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if ({RSP_VALID, RSP_DATA, BUSY} !== {1'b1, 4'h6, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_rsp1: vld=%b data=%h busy=%b, required 1 6 1", RSP_VALID, RSP_DATA, BUSY);
        end
        next_cycle();
        @(negedge CLK);
        n_checks++;
        if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drained: vld=%b busy=%b, required 0 0", RSP_VALID, BUSY);
        end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram_mem[i] <= 4'(15 - i);
        test_reset();
        test_write_read();
        test_wrap();
        test_credit();
        test_reset_mid();
        test_verify();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
